// File: rtl/lsu_ld_sched.sv
// Load scheduler: turns one iram/wram load command into a sequence of AXI read
// bursts and streams each returned 64-bit beat into the selected on-chip RAM.
module lsu_ld_sched #(
    parameter int         DATA_W = 64,
    parameter int         RAM_AW = 12,
    parameter logic [7:0] AXI_ID = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_wram,
    input  logic [30:0]       cmd_dram_addr,
    input  logic [7:0]        cmd_num,
    input  logic [7:0]        cmd_len,
    input  logic [2:0]        cmd_str,
    input  logic [RAM_AW-1:0] cmd_ram_addr,
    output logic              ar_vld,
    input  logic              ar_rdy,
    output logic [30:0]       ar_addr,
    output logic [7:0]        ar_len,
    output logic [7:0]        ar_id,
    input  logic              r_vld,
    output logic              r_rdy,
    input  logic [7:0]        r_id,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    output logic              iram_we,
    output logic              wram_we,
    output logic [RAM_AW-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, AR, DATA, FIN} state_e;

    state_e              state_q, state_d;
    logic                wram_q, wram_d;
    logic [7:0]          num_q, num_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          str_q, str_d;
    logic [7:0]          bcnt_q, bcnt_d;
    logic [8:0]          beat_q, beat_d;
    logic [30:0]         row_q, row_d;
    logic [RAM_AW-1:0]   ptr_q, ptr_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                cmd_rdy_q, cmd_rdy_d;
    logic                ar_vld_q, ar_vld_d;
    logic                r_rdy_q, r_rdy_d;
    logic                iram_we_q, iram_we_d;
    logic                wram_we_q, wram_we_d;
    logic [RAM_AW-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [30:0]         row_step;

    // Byte distance between consecutive rows: one burst of beats scaled by the pitch shift.
    assign row_step = (31'(len_q) + 31'd1) << (3 + str_q);

    always_comb begin
        // NOTE: every next-state value is defaulted first so no latch is inferred.
        state_d   = state_q;
        wram_d    = wram_q;
        num_d     = num_q;
        len_d     = len_q;
        str_d     = str_q;
        bcnt_d    = bcnt_q;
        beat_d    = beat_q;
        row_d     = row_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        done_d    = 1'b0;
        iram_we_d = 1'b0;
        wram_we_d = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_vld) begin
                    wram_d  = cmd_wram;
                    num_d   = cmd_num;
                    len_d   = cmd_len;
                    str_d   = cmd_str;
                    row_d   = cmd_dram_addr;
                    ptr_d   = cmd_ram_addr;
                    bcnt_d  = 8'd0;
                    err_d   = 1'b0;
                    state_d = (cmd_num == 8'd0) ? FIN : AR;
                end
            end
            AR: begin
                if (ar_rdy) begin
                    beat_d  = 9'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_vld && r_rdy_q) begin
                    if (beat_q <= {1'b0, len_q}) begin
                        iram_we_d = ~wram_q;
                        wram_we_d = wram_q;
                        waddr_d   = ptr_q;
                        wdata_d   = r_data;
                        ptr_d     = ptr_q + 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (r_resp != 2'b00 || r_id != AXI_ID) begin
                        err_d = 1'b1;
                    end
                    if (beat_q != 9'd256) begin
                        beat_d = beat_q + 9'd1;
                    end
                    if (r_last) begin
                        if (beat_q < {1'b0, len_q}) begin
                            err_d = 1'b1;
                        end
                        bcnt_d  = bcnt_q + 8'd1;
                        row_d   = row_q + row_step;
                        state_d = (bcnt_q + 8'd1 == num_q) ? FIN : AR;
                    end
                end
            end
            FIN: begin
                // First FIN cycle carries the final RAM write; the pulse follows it.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_rdy_d = (state_d == IDLE);
        ar_vld_d  = (state_d == AR);
        r_rdy_d   = (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wram_q    <= 1'b0;
            num_q     <= '0;
            len_q     <= '0;
            str_q     <= '0;
            bcnt_q    <= '0;
            beat_q    <= '0;
            row_q     <= '0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            cmd_rdy_q <= 1'b1;
            ar_vld_q  <= 1'b0;
            r_rdy_q   <= 1'b0;
            iram_we_q <= 1'b0;
            wram_we_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            wram_q    <= wram_d;
            num_q     <= num_d;
            len_q     <= len_d;
            str_q     <= str_d;
            bcnt_q    <= bcnt_d;
            beat_q    <= beat_d;
            row_q     <= row_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
            done_q    <= done_d;
            cmd_rdy_q <= cmd_rdy_d;
            ar_vld_q  <= ar_vld_d;
            r_rdy_q   <= r_rdy_d;
            iram_we_q <= iram_we_d;
            wram_we_q <= wram_we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign cmd_rdy   = cmd_rdy_q;
    assign ar_vld    = ar_vld_q;
    assign ar_addr   = row_q;
    assign ar_len    = len_q;
    assign ar_id     = AXI_ID;
    assign r_rdy     = r_rdy_q;
    assign iram_we   = iram_we_q;
    assign wram_we   = wram_we_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu_ld_sched.sv
// Directed bench for lsu_ld_sched: a transaction-level model (expected AR
// addresses, expected RAM writes, expected error) checked every cycle.
module tb_lsu_ld_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld, cmd_rdy, cmd_wram;
    logic [30:0] cmd_dram_addr;
    logic [7:0]  cmd_num, cmd_len;
    logic [2:0]  cmd_str;
    logic [11:0] cmd_ram_addr;
    logic        ar_vld, ar_rdy;
    logic [30:0] ar_addr;
    logic [7:0]  ar_len, ar_id;
    logic        r_vld, r_rdy, r_last;
    logic [7:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        iram_we, wram_we;
    logic [11:0] ram_waddr;
    logic [63:0] ram_wdata;
    logic        done, err;

    lsu_ld_sched dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wram(cmd_wram),
        .cmd_dram_addr(cmd_dram_addr), .cmd_num(cmd_num), .cmd_len(cmd_len),
        .cmd_str(cmd_str), .cmd_ram_addr(cmd_ram_addr),
        .ar_vld(ar_vld), .ar_rdy(ar_rdy), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
        .r_vld(r_vld), .r_rdy(r_rdy), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
        .r_last(r_last),
        .iram_we(iram_we), .wram_we(wram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wram;
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          done_seen   = 0;
    wr_t         exp_wr[$];
    logic [30:0] exp_ar[$];
    logic [30:0] lit_ar[$];
    logic [11:0] lit_waddr[$];
    logic        exp_err = 1'b0;
    logic [7:0]  m_len;
    logic        m_wram;
    logic [11:0] m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the transaction model.
    always @(negedge clk) begin
        if (iram_we || wram_we) begin
            check("we_onehot", 64'(iram_we && wram_we), 0);
            check("wr_expected", 64'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_sel", {iram_we, wram_we}, {~w.wram, w.wram});
                check("wr_addr", ram_waddr, w.addr);
                check("wr_data", ram_wdata, w.data);
            end
            if (lit_waddr.size() != 0) check("lit_waddr", ram_waddr, lit_waddr.pop_front());
        end
        if (ar_vld) begin
            check("ar_expected", 64'(exp_ar.size() != 0), 1);
            if (exp_ar.size() != 0) begin
                check("ar_addr", ar_addr, exp_ar[0]);
                check("ar_len", ar_len, m_len);
                check("ar_id", ar_id, 8'h01);
                if (ar_rdy) begin
                    void'(exp_ar.pop_front());
                    if (lit_ar.size() != 0) check("lit_ar", ar_addr, lit_ar.pop_front());
                end
            end
        end
        if (done) begin
            done_seen++;
            check("done_err", err, exp_err);
            check("done_wr_drained", exp_wr.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic wram, input logic [30:0] dram, input logic [7:0] num,
                             input logic [7:0] len, input logic [2:0] str, input logic [11:0] raddr);
        int t = 0;
        while (!cmd_rdy && t < 100) begin tick(); t++; end
        check("cmd_rdy_wait", cmd_rdy, 1);
        m_len  = len;
        m_wram = wram;
        m_ptr  = raddr;
        exp_err = 1'b0;
        cmd_vld = 1'b1; cmd_wram = wram; cmd_dram_addr = dram;
        cmd_num = num; cmd_len = len; cmd_str = str; cmd_ram_addr = raddr;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic ar_hs(input int delay);
        int t = 0;
        while (!ar_vld && t < 100) begin tick(); t++; end
        check("ar_vld_wait", ar_vld, 1);
        repeat (delay) tick();
        ar_rdy = 1'b1;
        tick();
        ar_rdy = 1'b0;
    endtask

    // Model rules: beats up to len are written at the running RAM pointer;
    // later beats are dropped; bad resp/id, dropped beats or early last flag err.
    task automatic send_beat(input int idx, input logic last, input logic [1:0] resp,
                             input logic [7:0] id);
        wr_t w;
        logic [63:0] d;
        d = {$urandom, $urandom};
        if (idx <= int'(m_len)) begin
            w.wram = m_wram; w.addr = m_ptr; w.data = d;
            exp_wr.push_back(w);
            m_ptr = m_ptr + 12'd1;
        end else begin
            exp_err = 1'b1;
        end
        if (resp != 2'b00 || id != 8'h01) exp_err = 1'b1;
        if (last && idx < int'(m_len)) exp_err = 1'b1;
        r_vld = 1'b1; r_data = d; r_resp = resp; r_id = id; r_last = last;
        tick();
        r_vld = 1'b0; r_last = 1'b0; r_resp = 2'b00; r_id = 8'h01;
    endtask

    // mode 0 clean, 1 resp error on beat 1 + r_last on beat 2, 2 one extra beat, 3 bad id
    task automatic run_cmd(input logic wram, input logic [30:0] dram, input logic [7:0] num,
                           input logic [7:0] len, input logic [2:0] str, input logic [11:0] raddr,
                           input int ar_delay, input int mode);
        int base;
        int nb;
        logic [30:0] pitch;
        base  = done_seen;
        pitch = (31'(len) + 31'd1) << (3 + str);
        for (int b = 0; b < int'(num); b++) exp_ar.push_back(dram + 31'(b) * pitch);
        drive_cmd(wram, dram, num, len, str, raddr);
        check("cmd_to_ar", ar_vld, 1);
        for (int b = 0; b < int'(num); b++) begin
            ar_hs(b == 0 ? ar_delay : 0);
            nb = int'(len) + 1;
            if (b == 0 && mode == 1) nb = 3;
            if (b == 0 && mode == 2) nb = int'(len) + 2;
            for (int i = 0; i < nb; i++) begin
                send_beat(i, i == nb - 1,
                          (b == 0 && mode == 1 && i == 1) ? 2'b10 : 2'b00,
                          (b == 0 && mode == 3 && i == 0) ? 8'h02 : 8'h01);
            end
            if (b < int'(num) - 1) begin
                check("burst_gap_ar", ar_vld, 1);
            end else begin
                check("done_at_1", done, 0);
                tick();
                check("done_at_2", done, 1);
                check("fin_busy", cmd_rdy, 0);
            end
        end
        repeat (3) tick();
        check("one_done", done_seen - base, 1);
        check("wr_drained", exp_wr.size(), 0);
        check("cmd_rdy_back", cmd_rdy, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1; cmd_vld = 1'b0; cmd_wram = 1'b0; cmd_dram_addr = '0; cmd_num = '0;
        cmd_len = '0; cmd_str = '0; cmd_ram_addr = '0; ar_rdy = 1'b0; r_vld = 1'b0;
        r_id = 8'h01; r_data = '0; r_resp = '0; r_last = 1'b0;
        m_len = '0; m_wram = 1'b0; m_ptr = '0;
        repeat (3) tick();
        check("rst_cmd_rdy", cmd_rdy, 1);
        check("rst_outs", {ar_vld, r_rdy, iram_we, wram_we, done, err}, 0);
        check("rst_addrs", {ar_addr, ram_waddr}, 0);
        rst = 1'b0;
        tick();

        // Single burst into iram.
        lit_ar.push_back(31'h100);
        for (int i = 0; i < 4; i++) lit_waddr.push_back(12'h010 + 12'(i));
        run_cmd(1'b0, 31'h100, 8'd1, 8'd3, 3'd0, 12'h010, 0, 0);
        check("t1_err", err, 0);

        // Strided rows into wram, contiguous RAM pointer.
        lit_ar.push_back(31'h1000); lit_ar.push_back(31'h1040); lit_ar.push_back(31'h1080);
        for (int i = 0; i < 6; i++) lit_waddr.push_back(12'h200 + 12'(i));
        run_cmd(1'b1, 31'h1000, 8'd3, 8'd1, 3'd2, 12'h200, 0, 0);

        // AR backpressure and RAM address wrap.
        lit_waddr.push_back(12'hFFE); lit_waddr.push_back(12'hFFF);
        lit_waddr.push_back(12'h000); lit_waddr.push_back(12'h001);
        run_cmd(1'b0, 31'h2000, 8'd1, 8'd3, 3'd0, 12'hFFE, 5, 0);

        // Error cases, then a clean command clears err.
        run_cmd(1'b1, 31'h3000, 8'd1, 8'd3, 3'd0, 12'h100, 0, 1);
        check("t4_err", err, 1);
        run_cmd(1'b0, 31'h4000, 8'd2, 8'd1, 3'd1, 12'h300, 0, 2);
        check("t4b_err", err, 1);
        run_cmd(1'b1, 31'h5000, 8'd2, 8'd2, 3'd0, 12'h400, 1, 3);
        check("t4c_err", err, 1);
        run_cmd(1'b0, 31'h7FFF_FFC0, 8'd2, 8'd7, 3'd0, 12'h500, 0, 0);
        check("t5_err_cleared", err, 0);

        // No-op command, plus a command presented while busy.
        base = done_seen;
        drive_cmd(1'b0, 31'h6000, 8'd0, 8'd3, 3'd0, 12'h000);
        check("noop_done_at_1", done, 0);
        check("busy_cmd_rdy", cmd_rdy, 0);
        cmd_vld = 1'b1; cmd_num = 8'd2;
        tick();
        cmd_vld = 1'b0;
        check("noop_done_at_2", done, 1);
        check("noop_err", err, 0);
        repeat (5) tick();
        check("noop_one_done", done_seen - base, 1);
        check("noop_no_ar", ar_vld, 0);

        // Reset in the middle of a burst.
        exp_ar.push_back(31'h300);
        drive_cmd(1'b1, 31'h300, 8'd1, 8'd3, 3'd0, 12'h050);
        ar_hs(0);
        send_beat(0, 1'b0, 2'b00, 8'h01);
        send_beat(1, 1'b0, 2'b00, 8'h01);
        rst = 1'b1;
        tick();
        check("mid_rst_cmd_rdy", cmd_rdy, 1);
        check("mid_rst_outs", {ar_vld, r_rdy, iram_we, wram_we, done, err}, 0);
        check("mid_rst_addrs", {ar_addr, ram_waddr}, 0);
        check("mid_rst_wdata", ram_wdata, 0);
        rst = 1'b0;
        exp_wr.delete();
        tick();
        run_cmd(1'b1, 31'h800, 8'd2, 8'd3, 3'd1, 12'h0F0, 2, 0);
        check("post_rst_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
